// File: rtl/cache_bus_pkg.sv
// Shared request/response encodings and FSM state type for the MESI snoop bus.
package cache_bus_pkg;

  localparam logic [1:0] NO_REQ     = 2'b00;
  localparam logic [1:0] READ       = 2'b01;
  localparam logic [1:0] RWITM      = 2'b10;
  localparam logic [1:0] INVALIDATE = 2'b11;

  localparam logic [1:0] NO_RSP      = 2'b00;
  localparam logic [1:0] SNOOP_FOUND = 2'b01;
  localparam logic [1:0] FETCH_MEM   = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    SNOOP = 3'd2,
    MEM   = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Snoop-bus bundle between the cache controllers, the arbiter and memory.
// wb_i / wb_addr_i exist only when SNOOP_BUS_WB_EN is defined.
interface snoop_bus_arbiter_if #(
  parameter int NUM_CORE   = 4,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_CORE-1:0][1:0]            bus_req_i;
  logic [NUM_CORE-1:0][ADDR_WIDTH-1:0] bus_addr_i;
  logic [NUM_CORE-1:0][1:0]            bus_rsp_o;
  logic                                snp_valid_o;
  logic [1:0]                          snp_req_o;
  logic [ADDR_WIDTH-1:0]               snp_addr_o;
  logic [NUM_CORE-1:0]                 snp_src_o;
  logic [NUM_CORE-1:0]                 snp_hit_i;
  logic                                mem_req_o;
  logic                                mem_we_o;
  logic [ADDR_WIDTH-1:0]               mem_addr_o;
  logic                                mem_ack_i;
  logic                                busy_o;
`ifdef SNOOP_BUS_WB_EN
  logic [NUM_CORE-1:0]                 wb_i;
  logic [NUM_CORE-1:0][ADDR_WIDTH-1:0] wb_addr_i;
`endif

  modport master (
`ifdef SNOOP_BUS_WB_EN
    input  wb_i, wb_addr_i,
`endif
    input  bus_req_i, bus_addr_i, snp_hit_i, mem_ack_i,
    output bus_rsp_o, snp_valid_o, snp_req_o, snp_addr_o, snp_src_o,
    output mem_req_o, mem_we_o, mem_addr_o, busy_o
  );

  modport slave (
`ifdef SNOOP_BUS_WB_EN
    output wb_i, wb_addr_i,
`endif
    output bus_req_i, bus_addr_i, snp_hit_i, mem_ack_i,
    input  bus_rsp_o, snp_valid_o, snp_req_o, snp_addr_o, snp_src_o,
    input  mem_req_o, mem_we_o, mem_addr_o, busy_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after rr_ptr wins.
// Zero latency; the pointer itself is owned by the parent.
module rr_arbiter #(
  parameter int NUM_CORE = 4
) (
  input  logic [NUM_CORE-1:0]         req,
  input  logic [$clog2(NUM_CORE)-1:0] rr_ptr,
  output logic [NUM_CORE-1:0]         gnt,
  output logic [$clog2(NUM_CORE)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(NUM_CORE);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_CORE; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CORE;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop-bus controller: grant -> snoop -> memory fetch on miss -> one-cycle bus_rsp.
// Optional victim write-back before the snoop when SNOOP_BUS_WB_EN is defined.
module snoop_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int NUM_CORE   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  snoop_bus_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_CORE);

  state_t                              state;
  logic [IDX_W-1:0]                    rr_ptr;
  logic [IDX_W-1:0]                    grant;
  logic [IDX_W-1:0]                    gnt_idx;
  logic [NUM_CORE-1:0]                 req_vec;
  logic [NUM_CORE-1:0]                 gnt_oh;
  logic [NUM_CORE-1:0]                 lat_src;
  logic [1:0]                          lat_req;
  logic [ADDR_WIDTH-1:0]               lat_addr;
  logic                                snp_valid;
  logic                                mem_req;
  logic [ADDR_WIDTH-1:0]               mem_addr;
  logic [NUM_CORE-1:0][1:0]            rsp;
  logic                                hit;
`ifdef SNOOP_BUS_WB_EN
  logic                                mem_we;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CORE; i++) begin
      req_vec[i] = (bus.bus_req_i[i] != NO_REQ);
    end
  end

  rr_arbiter #(.NUM_CORE(NUM_CORE)) u_rr (
    .req     (req_vec),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  // The requester's own copy never counts as a peer hit.
  assign hit = |(bus.snp_hit_i & ~lat_src);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_CORE - 1);
      grant     <= '0;
      lat_src   <= '0;
      lat_req   <= NO_REQ;
      lat_addr  <= '0;
      snp_valid <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      rsp       <= '0;
`ifdef SNOOP_BUS_WB_EN
      mem_we    <= 1'b0;
`endif
    end else begin
      snp_valid <= 1'b0;
      rsp       <= '0;
      case (state)
        IDLE: begin
          if (|gnt_oh) begin
            grant    <= gnt_idx;
            lat_src  <= gnt_oh;
            lat_req  <= bus.bus_req_i[gnt_idx];
            lat_addr <= bus.bus_addr_i[gnt_idx];
`ifdef SNOOP_BUS_WB_EN
            if (bus.wb_i[gnt_idx]) begin
              state    <= WB;
              mem_req  <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= bus.wb_addr_i[gnt_idx];
            end else begin
              state     <= SNOOP;
              snp_valid <= 1'b1;
            end
`else
            state     <= SNOOP;
            snp_valid <= 1'b1;
`endif
          end
        end
`ifdef SNOOP_BUS_WB_EN
        WB: begin
          if (bus.mem_ack_i) begin
            state     <= SNOOP;
            snp_valid <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
          end
        end
`endif
        SNOOP: begin
          if (lat_req == INVALIDATE || hit) begin
            state      <= RESP;
            rsp[grant] <= SNOOP_FOUND;
          end else begin
            state    <= MEM;
            mem_req  <= 1'b1;
            mem_addr <= lat_addr;
          end
        end
        MEM: begin
          if (bus.mem_ack_i) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            rsp[grant] <= FETCH_MEM;
          end
        end
        RESP: begin
          rr_ptr <= grant;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_rsp_o   = rsp;
  assign bus.snp_valid_o = snp_valid;
  assign bus.snp_req_o   = snp_valid ? lat_req  : NO_REQ;
  assign bus.snp_addr_o  = snp_valid ? lat_addr : '0;
  assign bus.snp_src_o   = snp_valid ? lat_src  : '0;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.busy_o      = (state != IDLE);
`ifdef SNOOP_BUS_WB_EN
  assign bus.mem_we_o    = mem_we;
`else
  assign bus.mem_we_o    = 1'b0;
`endif

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Shared snoop-bus controller for the MESI cache array. It collects the per-core bus requests (`send_bus_req`) issued by each cache's CPU-request FSM and grants the bus to one core at a time, round-robin. For the granted request it broadcasts a snoop to every other cache, falls back to a memory fetch if no peer holds the line, and returns a one-cycle `bus_rsp` to the requester. It sits between the per-core cache controllers and the memory port.

## Interface
- `NUM_CORE`, default 4: number of cache controllers, at least 2.
- `ADDR_WIDTH`, default 32: line address width.
- `clk` input, 1: sole clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `bus_req_i` input, [NUM_CORE][2]: per-core request code (NO_REQ/READ/RWITM/INVALIDATE).
- `bus_addr_i` input, [NUM_CORE][ADDR_WIDTH]: per-core line address.
- `bus_rsp_o` output, [NUM_CORE][2]: per-core response code (NO_RSP/SNOOP_FOUND/FETCH_MEM).
- `snp_valid_o` output, 1: snoop broadcast valid.
- `snp_req_o` output, 2: broadcast request code.
- `snp_addr_o` output, ADDR_WIDTH: broadcast address.
- `snp_src_o` output, NUM_CORE: one-hot originator. Snoopers ignore a broadcast from themselves.
- `snp_hit_i` input, NUM_CORE: per-core "holds valid copy". Combinational reply, same cycle as `snp_valid_o`.
- `mem_req_o` output, 1: memory access request, level, held until ack.
- `mem_we_o` output, 1: 1 = write-back, 0 = fetch.
- `mem_addr_o` output, ADDR_WIDTH: memory address.
- `mem_ack_i` input, 1: memory completion, one-cycle pulse.
- `busy_o` output, 1: high whenever state ≠ IDLE.
- The following two ports exist only with `SNOOP_BUS_WB_EN`:
  - `wb_i` input, [NUM_CORE]: requester must write back a dirty victim first.
  - `wb_addr_i` input, [NUM_CORE][ADDR_WIDTH]: victim address.

## Operation
- States: IDLE, WB (with macro only), SNOOP, MEM, RESP.
- **IDLE**
  - Any `bus_req_i[i]` ≠ NO_REQ triggers a grant: search starts at `rr_ptr+1` mod NUM_CORE, first requester wins.
  - On grant, latch the grant index, request code and address (plus `wb_i` and `wb_addr_i` with the macro).
  - Next state is WB if the latched wb flag is set, otherwise SNOOP.
- **WB**
  - Drive `mem_req_o=1`, `mem_we_o=1`, `mem_addr_o` = latched victim address.
  - On `mem_ack_i`, go to SNOOP.
- **SNOOP**
  - One cycle: `snp_valid_o=1` with the latched code, address and `snp_src_o`.
  - Sample `hit = |(snp_hit_i & ~snp_src_o)`. The requester's own hit bit is always masked.
  - INVALIDATE: go to RESP with SNOOP_FOUND, regardless of hit.
  - READ or RWITM with hit: go to RESP with SNOOP_FOUND.
  - READ or RWITM without hit: go to MEM.
- **MEM**
  - Drive `mem_req_o=1`, `mem_we_o=0`, `mem_addr_o` = latched address.
  - On `mem_ack_i`, go to RESP with FETCH_MEM.
- **RESP**
  - `bus_rsp_o[grant]` = latched response for exactly one cycle. All other entries stay NO_RSP.
  - Set `rr_ptr = grant`, then go to IDLE.
- Requests are latched at grant. Later changes to `bus_req_i` or `bus_addr_i` of the granted core have no effect until RESP.
- IDLE takes one cycle after RESP before re-arbitrating. This gives the requester time to drop its request after seeing the response.
- `mem_ack_i` outside WB or MEM is ignored.
- `snp_hit_i` outside SNOOP is ignored.

## Timing
- Reset values:
  - State IDLE, `rr_ptr = NUM_CORE-1`, so core 0 has priority after reset.
  - All outputs 0 / NO_RSP, and all latches 0.
- Request seen in IDLE at cycle t:
  - SNOOP at t+1.
  - A snoop-satisfied response appears in `bus_rsp_o` at t+2.
- Memory path: `mem_req_o` rises at t+2. With `mem_ack_i` at cycle k, the response appears at k+1 and `mem_req_o` drops at k+1.
- `mem_ack_i` in the same cycle `mem_req_o` first rises is legal: response at the next cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. The aborted request gets no response.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- `SNOOP_BUS_WB_EN` defined:
  - `wb_i` / `wb_addr_i` ports exist and the WB state exists.
  - The victim write-back always completes before the snoop of the new line.
- Not defined:
  - Those ports and the WB state are absent.
  - `mem_we_o` is tied 0.
  - Write-back is handled outside this block.

## Structure
- Shared package `cache_bus_pkg` holds:
  - Request codes: NO_REQ=2'b00, READ=2'b01, RWITM=2'b10, INVALIDATE=2'b11.
  - Response codes: NO_RSP=2'b00, SNOOP_FOUND=2'b01, FETCH_MEM=2'b10.
  - The state enum typedef.
- One sub-module, `rr_arbiter`: parameterized NUM_CORE round-robin picker. Inputs are the request vector and `rr_ptr`; outputs are a one-hot grant and the grant index. It is purely combinational; the pointer is kept in the parent.

## Test plan
- Core 0 READ at 0x40, no `snp_hit_i`, `mem_ack_i` 3 cycles after `mem_req_o` rises → `mem_addr_o`=0x40, `mem_we_o`=0, and `bus_rsp_o[0]`=FETCH_MEM for exactly one cycle, the cycle after ack.
- Core 1 READ at 0x80 with `snp_hit_i`=4'b0100 → `snp_src_o`=4'b0010, `bus_rsp_o[1]`=SNOOP_FOUND at t+2, and no `mem_req_o`.
- Core 2 RWITM with only `snp_hit_i[2]` set → own hit is masked, so the MEM path is taken and the response is FETCH_MEM. Core 3 INVALIDATE → SNOOP_FOUND at t+2.
- All 4 cores request continuously from reset → grant order 0,1,2,3,0. Each response is one cycle, each grant is separated by one IDLE cycle, and no response goes to a non-granted core.
- `rst_n` low during MEM with `mem_req_o`=1 → `mem_req_o` and `busy_o` drop at once, state is IDLE, and the next arbitration starts from core 0.
- `SNOOP_BUS_WB_EN`: core 0 READ 0x40 with `wb_i[0]`=1, `wb_addr_i`=0x100 → memory write to 0x100 acked first, then snoop of 0x40, then the response.
